// File: rtl/cnn_conv_3x3_64_lane_ctrl.sv
// Lane sequencer for the 4-lane conv array: splits weight and channel-interleaved pixel streams per lane, counts results.
// Latency: lane outputs registered, 1 cycle after acceptance. Backpressure: ready is a pure function of state, so no overrun.
// Optional build macro CNN_LANE_CTRL_PERF_EN adds cycle_cnt / stall_cnt outputs.
module cnn_conv_3x3_64_lane_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int IMAGE_WIDTH     = 612,
    parameter int IMAGE_HEIGHT    = 612,
    parameter int CHANNEL_NUM_IN  = 64,
    parameter int CHANNEL_NUM_OUT = 64,
    parameter int KERNEL          = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stride2_cfg,
    input  logic                  valid_weight_in,
    input  logic [DATA_WIDTH-1:0] weight_in,
    output logic                  weight_ready,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic                  pxl_ready,
    output logic                  valid_weight_out1,
    output logic                  valid_weight_out2,
    output logic                  valid_weight_out3,
    output logic                  valid_weight_out4,
    output logic [DATA_WIDTH-1:0] weight_out1,
    output logic [DATA_WIDTH-1:0] weight_out2,
    output logic [DATA_WIDTH-1:0] weight_out3,
    output logic [DATA_WIDTH-1:0] weight_out4,
    output logic                  valid_out1,
    output logic                  valid_out2,
    output logic                  valid_out3,
    output logic                  valid_out4,
    output logic [DATA_WIDTH-1:0] pxl_out1,
    output logic [DATA_WIDTH-1:0] pxl_out2,
    output logic [DATA_WIDTH-1:0] pxl_out3,
    output logic [DATA_WIDTH-1:0] pxl_out4,
    output logic                  stride2,
    input  logic                  res_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  err
`ifdef CNN_LANE_CTRL_PERF_EN
    ,
    output logic [31:0]           cycle_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    localparam int CPL     = CHANNEL_NUM_IN / 4;
    localparam int WPL     = KERNEL * KERNEL * CPL * CHANNEL_NUM_OUT;
    localparam int NPX     = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNEL_NUM_IN;
    localparam int NRES_S1 = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNEL_NUM_OUT;
    localparam int NRES_S2 = (IMAGE_WIDTH / 2) * (IMAGE_HEIGHT / 2) * CHANNEL_NUM_OUT;
    localparam int WSW     = $clog2(WPL + 1);
    localparam int CSW     = $clog2(CPL + 1);
    localparam int PCW     = $clog2(NPX + 1);
    localparam int RCW     = $clog2(NRES_S1 + 1);

    typedef enum logic [1:0] {IDLE, LOAD_W, RUN, DRAIN} state_t;

    state_t                r_state, w_state_nxt;
    logic [WSW-1:0]        r_w_sub;
    logic [1:0]            r_w_lane;
    logic [CSW-1:0]        r_p_sub;
    logic [1:0]            r_p_lane;
    logic [PCW-1:0]        r_p_cnt;
    logic [RCW-1:0]        r_res_cnt, w_res_nxt, w_nres;
    logic                  r_stride2, r_done, r_err;
    logic [3:0]            r_vw, r_vp;
    logic [DATA_WIDTH-1:0] r_w_dat [4];
    logic [DATA_WIDTH-1:0] r_p_dat [4];
    logic                  w_start_acc, w_w_acc, w_p_acc, w_w_last, w_p_last;
    logic                  w_res_inc, w_done_nxt, w_drop;

    assign w_start_acc = start && (r_state == IDLE);
    assign w_w_acc     = valid_weight_in && (r_state == LOAD_W);
    assign w_p_acc     = valid_in && (r_state == RUN);
    assign w_w_last    = w_w_acc && (r_w_lane == 2'd3) && (r_w_sub == WSW'(WPL - 1));
    assign w_p_last    = w_p_acc && (r_p_cnt == PCW'(NPX - 1));
    assign w_nres      = r_stride2 ? RCW'(NRES_S2) : RCW'(NRES_S1);
    // Result count saturates at the target so extra pulses cannot wrap it.
    assign w_res_inc   = res_valid && ((r_state == RUN) || (r_state == DRAIN)) && (r_res_cnt != w_nres);
    assign w_res_nxt   = r_res_cnt + RCW'(w_res_inc);
    assign w_drop      = (valid_weight_in && (r_state != LOAD_W))
                      || (valid_in && (r_state != RUN))
                      || (res_valid && ((r_state == IDLE) || (r_state == LOAD_W)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        weight_ready = 1'b0;
        pxl_ready    = 1'b0;
        w_done_nxt   = 1'b0;
        case (r_state)
            IDLE: if (start) w_state_nxt = LOAD_W;
            LOAD_W: begin
                weight_ready = 1'b1;
                if (w_w_last) w_state_nxt = RUN;
            end
            RUN: begin
                pxl_ready = 1'b1;
                if (w_p_last) begin
                    if (w_res_nxt == w_nres) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_res_nxt == w_nres) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Lane/sub-lane counters avoid dividing by WPL or CPL in hardware.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_w_sub   <= '0;
            r_w_lane  <= '0;
            r_p_sub   <= '0;
            r_p_lane  <= '0;
            r_p_cnt   <= '0;
            r_res_cnt <= '0;
        end else if (w_start_acc) begin
            r_w_sub   <= '0;
            r_w_lane  <= '0;
            r_p_sub   <= '0;
            r_p_lane  <= '0;
            r_p_cnt   <= '0;
            r_res_cnt <= '0;
        end else begin
            if (w_w_acc) begin
                if (r_w_sub == WSW'(WPL - 1)) begin
                    r_w_sub  <= '0;
                    r_w_lane <= r_w_lane + 2'd1;
                end else begin
                    r_w_sub  <= r_w_sub + WSW'(1);
                end
            end
            if (w_p_acc) begin
                r_p_cnt <= r_p_cnt + PCW'(1);
                if (r_p_sub == CSW'(CPL - 1)) begin
                    r_p_sub  <= '0;
                    r_p_lane <= r_p_lane + 2'd1;
                end else begin
                    r_p_sub  <= r_p_sub + CSW'(1);
                end
            end
            r_res_cnt <= w_res_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vw <= '0;
            r_vp <= '0;
            for (int i = 0; i < 4; i++) begin
                r_w_dat[i] <= '0;
                r_p_dat[i] <= '0;
            end
        end else begin
            r_vw <= '0;
            r_vp <= '0;
            if (w_w_acc) begin
                r_vw[r_w_lane]    <= 1'b1;
                r_w_dat[r_w_lane] <= weight_in;
            end
            if (w_p_acc) begin
                r_vp[r_p_lane]    <= 1'b1;
                r_p_dat[r_p_lane] <= pxl_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stride2 <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (w_start_acc) begin
                r_stride2 <= stride2_cfg;
                r_err     <= 1'b0;
            end else if (w_drop) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy              = (r_state != IDLE);
    assign done              = r_done;
    assign err               = r_err;
    assign stride2           = r_stride2;
    assign valid_weight_out1 = r_vw[0];
    assign valid_weight_out2 = r_vw[1];
    assign valid_weight_out3 = r_vw[2];
    assign valid_weight_out4 = r_vw[3];
    assign weight_out1       = r_w_dat[0];
    assign weight_out2       = r_w_dat[1];
    assign weight_out3       = r_w_dat[2];
    assign weight_out4       = r_w_dat[3];
    assign valid_out1        = r_vp[0];
    assign valid_out2        = r_vp[1];
    assign valid_out3        = r_vp[2];
    assign valid_out4        = r_vp[3];
    assign pxl_out1          = r_p_dat[0];
    assign pxl_out2          = r_p_dat[1];
    assign pxl_out3          = r_p_dat[2];
    assign pxl_out4          = r_p_dat[3];

`ifdef CNN_LANE_CTRL_PERF_EN
    logic [31:0] r_cycle_cnt, r_stall_cnt;

    // Both counters stop naturally once the FSM is back in IDLE, holding the last layer's figures.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if ((r_state != IDLE) && (r_cycle_cnt != '1))
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if ((r_state == RUN) && !valid_in && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_cnn_conv_3x3_64_lane_ctrl.sv
// Randomized directed bench for cnn_conv_3x3_64_lane_ctrl on a 4x4, 8-in/2-out channel layer.
module tb_cnn_conv_3x3_64_lane_ctrl;

    localparam int DW    = 32;
    localparam int IW    = 4;
    localparam int IH    = 4;
    localparam int CIN   = 8;
    localparam int COUT  = 2;
    localparam int K     = 3;
    localparam int CPL   = CIN / 4;
    localparam int WPL   = K * K * CPL * COUT;
    localparam int NW    = 4 * WPL;
    localparam int NPX   = IW * IH * CIN;
    localparam int NRES1 = IW * IH * COUT;
    localparam int NRES2 = (IW / 2) * (IH / 2) * COUT;

    logic          clk = 1'b0;
    logic          reset, start, stride2_cfg, valid_weight_in, valid_in, res_valid;
    logic [DW-1:0] weight_in, pxl_in;
    logic          weight_ready, pxl_ready, stride2, busy, done, err;
    logic          vw1, vw2, vw3, vw4, vp1, vp2, vp3, vp4;
    logic [DW-1:0] wo1, wo2, wo3, wo4, po1, po2, po3, po4;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] exp_w [4];
    logic [DW-1:0] exp_p [4];

    cnn_conv_3x3_64_lane_ctrl #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH),
        .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT), .KERNEL(K)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stride2_cfg(stride2_cfg),
        .valid_weight_in(valid_weight_in), .weight_in(weight_in), .weight_ready(weight_ready),
        .valid_in(valid_in), .pxl_in(pxl_in), .pxl_ready(pxl_ready),
        .valid_weight_out1(vw1), .valid_weight_out2(vw2), .valid_weight_out3(vw3), .valid_weight_out4(vw4),
        .weight_out1(wo1), .weight_out2(wo2), .weight_out3(wo3), .weight_out4(wo4),
        .valid_out1(vp1), .valid_out2(vp2), .valid_out3(vp3), .valid_out4(vp4),
        .pxl_out1(po1), .pxl_out2(po2), .pxl_out3(po3), .pxl_out4(po4),
        .stride2(stride2), .res_valid(res_valid), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lanes(input string tag, input logic [3:0] evw, input logic [3:0] evp);
        chk({tag, "_wvld"}, {vw4, vw3, vw2, vw1}, evw);
        chk({tag, "_pvld"}, {vp4, vp3, vp2, vp1}, evp);
        chk({tag, "_wdat12"}, {wo2, wo1}, {exp_w[1], exp_w[0]});
        chk({tag, "_wdat34"}, {wo4, wo3}, {exp_w[3], exp_w[2]});
        chk({tag, "_pdat12"}, {po2, po1}, {exp_p[1], exp_p[0]});
        chk({tag, "_pdat34"}, {po4, po3}, {exp_p[3], exp_p[2]});
    endtask

    task automatic do_start(input logic s2);
        start       = 1'b1;
        stride2_cfg = s2;
        tick();
        start       = 1'b0;
        stride2_cfg = !s2;
        chk("start_busy", busy, 1);
        chk("start_wready", weight_ready, 1);
        chk("start_pready", pxl_ready, 0);
        chk("start_stride2", stride2, s2);
        chk("start_err_clr", err, 0);
    endtask

    task automatic load_weights();
        for (int k = 0; k < NW; k++) begin
            while ($urandom_range(0, 3) == 0) begin
                tick();
                chk_lanes("w_gap", 4'b0000, 4'b0000);
            end
            chk("w_ready", weight_ready, 1);
            valid_weight_in = 1'b1;
            weight_in       = $urandom;
            tick();
            valid_weight_in = 1'b0;
            exp_w[k / WPL]  = weight_in;
            chk_lanes("w_acc", 4'b0001 << (k / WPL), 4'b0000);
        end
        chk("w_end_wready", weight_ready, 0);
        chk("w_end_pready", pxl_ready, 1);
    endtask

    // Result pulses ride along with the last nres_run pixels of the layer.
    task automatic run_pixels(input int nres_run, input int n);
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                tick();
                chk_lanes("p_gap", 4'b0000, 4'b0000);
            end
            chk("p_ready", pxl_ready, 1);
            valid_in  = 1'b1;
            pxl_in    = $urandom;
            res_valid = (i >= NPX - nres_run);
            tick();
            valid_in  = 1'b0;
            res_valid = 1'b0;
            exp_p[(i % CIN) / CPL] = pxl_in;
            chk_lanes("p_acc", 4'b0000, 4'b0001 << ((i % CIN) / CPL));
        end
    endtask

    task automatic finish_layer(input int nres, input int nres_run, input logic exp_err, input logic s2);
        if (nres_run == nres) begin
            chk("direct_done", done, 1);
            chk("direct_busy", busy, 0);
        end else begin
            chk("drain_done", done, 0);
            chk("drain_busy", busy, 1);
            chk("drain_pready", pxl_ready, 0);
            for (int j = nres_run; j < nres; j++) begin
                while ($urandom_range(0, 2) == 0) begin
                    tick();
                    chk("drain_gap_done", done, 0);
                end
                res_valid = 1'b1;
                tick();
                res_valid = 1'b0;
                chk("res_done", done, (j == nres - 1));
                chk("res_busy", busy, (j != nres - 1));
            end
        end
        chk("end_stride2", stride2, s2);
        chk("end_err", err, exp_err);
        tick();
        chk("done_pulse_end", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        reset           = 1'b0;
        start           = 1'b0;
        stride2_cfg     = 1'b0;
        valid_weight_in = 1'b0;
        valid_in        = 1'b0;
        res_valid       = 1'b0;
        weight_in       = '0;
        pxl_in          = '0;
        for (int i = 0; i < 4; i++) begin
            exp_w[i] = '0;
            exp_p[i] = '0;
        end
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_stride2", stride2, 0);
        chk("rst_wready", weight_ready, 0);
        chk("rst_pready", pxl_ready, 0);
        chk_lanes("rst", 4'b0000, 4'b0000);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        chk("idle_busy0", busy, 0);
        chk("idle_wready0", weight_ready, 0);
        chk("idle_pready0", pxl_ready, 0);

        // Stride 1, some results arriving while pixels still stream
        do_start(1'b0);
        load_weights();
        run_pixels(5, NPX);
        finish_layer(NRES1, 5, 1'b0, 1'b0);

        // Stride 2, all results in drain
        do_start(1'b1);
        load_weights();
        run_pixels(0, NPX);
        finish_layer(NRES2, 0, 1'b0, 1'b1);

        // Dropped pixel during weight load, start while busy, final result with last pixel
        do_start(1'b0);
        valid_in = 1'b1;
        pxl_in   = $urandom;
        tick();
        valid_in = 1'b0;
        chk("drop_err", err, 1);
        chk("drop_busy", busy, 1);
        chk("drop_wready", weight_ready, 1);
        chk_lanes("drop", 4'b0000, 4'b0000);
        start       = 1'b1;
        stride2_cfg = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_err", err, 1);
        chk("busy_start_wready", weight_ready, 1);
        chk("busy_start_stride2", stride2, 0);
        load_weights();
        run_pixels(NRES1, NPX);
        finish_layer(NRES1, NRES1, 1'b1, 1'b0);

        // Abort mid-RUN via reset
        do_start(1'b0);
        load_weights();
        run_pixels(0, 50);
        #2 reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_w[i] = '0;
            exp_p[i] = '0;
        end
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pready", pxl_ready, 0);
        chk_lanes("abort", 4'b0000, 4'b0000);
        repeat (2) begin
            tick();
            chk("abort_rst_done", done, 0);
        end
        reset = 1'b1;
        repeat (3) begin
            tick();
            chk("abort_post_done", done, 0);
            chk("abort_post_busy", busy, 0);
        end

        // Full layer after the abort
        do_start(1'b0);
        load_weights();
        run_pixels(3, NPX);
        finish_layer(NRES1, 3, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
